// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the hazard/stall controller and the decoder, ID/EX, MEM and fetch stages.
// The slave side is the controller; the master side is whatever drives the pipeline inputs.
interface hazard_stall_ctrl_if #(
    parameter int OP_W        = 7,
    parameter int RA_W        = 5,
    parameter int STALL_CNT_W = 32
);
    logic [OP_W-1:0]        opCodeDec;
    logic [RA_W-1:0]        dataS1AddrDec;
    logic [RA_W-1:0]        dataS2AddrDec;
    logic [OP_W-1:0]        opCodeToHazard;
    logic [RA_W-1:0]        writeBackAddrEx;
    logic                   writeEnableEx;
    logic                   memAccess;
    logic                   dataCacheReady;
    logic                   branchTaken;
    logic                   locker;
    logic                   pcHold;
    logic                   ifIdHold;
    logic                   idExBubble;
    logic                   ifIdFlush;
    logic [STALL_CNT_W-1:0] stallCount;
    logic                   memTimeout;

    // No handshake: every input is a level sampled each cycle, every output is valid every cycle.
    modport slave (
        input  opCodeDec, dataS1AddrDec, dataS2AddrDec,
        input  opCodeToHazard, writeBackAddrEx, writeEnableEx,
        input  memAccess, dataCacheReady, branchTaken,
        output locker, pcHold, ifIdHold, idExBubble, ifIdFlush,
        output stallCount, memTimeout
    );

    modport master (
        output opCodeDec, dataS1AddrDec, dataS2AddrDec,
        output opCodeToHazard, writeBackAddrEx, writeEnableEx,
        output memAccess, dataCacheReady, branchTaken,
        input  locker, pcHold, ifIdHold, idExBubble, ifIdFlush,
        input  stallCount, memTimeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, cache-miss freeze and deferred branch flush,
// producing the ID/EX advance enable (locker) plus fetch-side hold/flush controls.
module hazard_stall_ctrl #(
    parameter int OP_W        = 7,
    parameter int RA_W        = 5,
    parameter int STALL_CNT_W = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OP_W-1:0]   OP_LOAD  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0]   OP_LUI   = OP_W'(7'b0110111);
    localparam logic [OP_W-1:0]   OP_AUIPC = OP_W'(7'b0010111);
    localparam logic [OP_W-1:0]   OP_JAL   = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0]   OP_REG   = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0]   OP_STORE = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0]   OP_BR    = OP_W'(7'b1100011);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    state_e                 state_q, state_d;
    logic                   pending_flush_q, pending_flush_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   mem_timeout_q, mem_timeout_d;

    logic rs1_used, rs2_used, load_use, miss_now, flush_req;
    logic locker_c, pc_hold_c, if_id_hold_c, id_ex_bubble_c, if_id_flush_c;
    logic count_stall;

    always_comb begin
        rs1_used = !((bus.opCodeDec == OP_LUI) || (bus.opCodeDec == OP_AUIPC) ||
                     (bus.opCodeDec == OP_JAL));
        rs2_used = (bus.opCodeDec == OP_REG) || (bus.opCodeDec == OP_STORE) ||
                   (bus.opCodeDec == OP_BR);
        load_use = (bus.opCodeToHazard == OP_LOAD) && bus.writeEnableEx &&
                   (bus.writeBackAddrEx != '0) &&
                   ((rs1_used && (bus.dataS1AddrDec == bus.writeBackAddrEx)) ||
                    (rs2_used && (bus.dataS2AddrDec == bus.writeBackAddrEx)));
        miss_now  = bus.memAccess && !bus.dataCacheReady;
        flush_req = bus.branchTaken || pending_flush_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            pending_flush_q <= 1'b0;
            wait_cnt_q      <= '0;
            stall_cnt_q     <= '0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            wait_cnt_q      <= wait_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pending_flush_d = pending_flush_q;
        wait_cnt_d      = wait_cnt_q;
        mem_timeout_d   = mem_timeout_q;
        locker_c        = 1'b1;
        pc_hold_c       = 1'b0;
        if_id_hold_c    = 1'b0;
        id_ex_bubble_c  = 1'b0;
        if_id_flush_c   = 1'b0;
        count_stall     = 1'b0;

        case (state_q)
            ST_RUN, ST_DRAIN: begin
                // DRAIN differs from RUN only in that pending_flush may be set on entry.
                state_d = ST_RUN;
                if (miss_now) begin
                    locker_c        = 1'b0;
                    pc_hold_c       = 1'b1;
                    if_id_hold_c    = 1'b1;
                    count_stall     = 1'b1;
                    pending_flush_d = pending_flush_q | bus.branchTaken;
                    wait_cnt_d      = '0;
                    state_d         = ST_MEM_WAIT;
                end else if (flush_req) begin
                    if_id_flush_c   = 1'b1;
                    id_ex_bubble_c  = 1'b1;
                    pending_flush_d = 1'b0;
                end else if (load_use) begin
                    pc_hold_c      = 1'b1;
                    if_id_hold_c   = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    count_stall    = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                locker_c        = 1'b0;
                pc_hold_c       = 1'b1;
                if_id_hold_c    = 1'b1;
                count_stall     = 1'b1;
                pending_flush_d = pending_flush_q | bus.branchTaken;
                if (bus.dataCacheReady) begin
                    wait_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    if ((wait_cnt_q + WAIT_ONE) == WAIT_MAX) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (count_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end
    end

    // Outputs are forced to the free-running pattern while reset is asserted.
    always_comb begin
        bus.locker     = reset ? locker_c       : 1'b1;
        bus.pcHold     = reset ? pc_hold_c      : 1'b0;
        bus.ifIdHold   = reset ? if_id_hold_c   : 1'b0;
        bus.idExBubble = reset ? id_ex_bubble_c : 1'b0;
        bus.ifIdFlush  = reset ? if_id_flush_c  : 1'b0;
        bus.stallCount = stall_cnt_q;
        bus.memTimeout = mem_timeout_q;
        dbg_state      = state_q;
    end

endmodule
